// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  // Fetch sequencing states; BOOT is a single settling cycle after reset
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

  // Word-addressed PC advances by one instruction per fetch
  localparam int PC_INCR = 1;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, memory and decode-side signals of the fetch stage
interface fetch_unit_if #(
  parameter int dataWidth = 32
);

  logic                 stall;
  logic                 redirect;
  logic [dataWidth-1:0] redirect_target;
  logic [dataWidth-1:0] imem_addr;
  logic [dataWidth-1:0] imem_data;
  logic [dataWidth-1:0] id_instr;
  logic [dataWidth-1:0] id_pc;
  logic                 id_valid;
  logic                 halted;

  // The fetch unit itself
  modport master (
    input  stall, redirect, redirect_target, imem_data,
    output imem_addr, id_instr, id_pc, id_valid, halted
  );

  // Surrounding pipeline control, instruction memory and decoder
  modport slave (
    output stall, redirect, redirect_target, imem_data,
    input  imem_addr, id_instr, id_pc, id_valid, halted
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, hold and load controls
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int                   dataWidth = 32,
  parameter logic [dataWidth-1:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_hold,
  input  logic                 i_flush,
  input  logic                 i_load,
  input  logic [dataWidth-1:0] i_instr,
  input  logic [dataWidth-1:0] i_pc,
  output logic [dataWidth-1:0] o_instr,
  output logic [dataWidth-1:0] o_pc,
  output logic                 o_valid
);

  logic [dataWidth-1:0] r_instr;
  logic [dataWidth-1:0] r_pc;
  logic                 r_valid;

  // Flush inserts a bubble and beats hold; hold beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_instr <= r_instr;
      r_pc    <= r_pc;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, fetch sequencing FSM and IF/ID capture
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   dataWidth = 32,
  parameter logic [dataWidth-1:0] RESET_PC  = '0,
  parameter logic [dataWidth-1:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [dataWidth-1:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_nxt;
  logic [dataWidth-1:0] r_pc;

  logic w_is_halt_word;
  logic w_pc_redirect;
  logic w_pc_incr;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_ifid_load;

  assign w_is_halt_word = (bus.imem_data == HALT_WORD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: redirect always resumes RUN, stall freezes the sequence
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect) begin
      w_state_nxt = RUN;
    end else if (!bus.stall) begin
      case (r_state)
        BOOT:    w_state_nxt = RUN;
        RUN:     w_state_nxt = w_is_halt_word ? HALT : RUN;
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  // Per-cycle PC and IF/ID controls in priority redirect > stall > state
  always_comb begin
    w_pc_redirect = 1'b0;
    w_pc_incr     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_ifid_load   = 1'b0;
    if (bus.redirect) begin
      w_pc_redirect = 1'b1;
      w_ifid_flush  = 1'b1;
    end else if (bus.stall) begin
      w_ifid_hold = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          w_ifid_load = 1'b1;
          // The halt word itself is delivered but the PC parks on it
          w_pc_incr   = !w_is_halt_word;
        end
        default: w_ifid_flush = 1'b1;
      endcase
    end
  end

  // Program counter; sequential advance wraps silently at the top of the space
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_pc_redirect) begin
      r_pc <= bus.redirect_target;
    end else if (w_pc_incr) begin
      r_pc <= r_pc + dataWidth'(PC_INCR);
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.halted    = (r_state == HALT);

  if_id_reg #(
    .dataWidth (dataWidth),
    .NOP_WORD  (NOP_WORD)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (w_ifid_hold),
    .i_flush (w_ifid_flush),
    .i_load  (w_ifid_load),
    .i_instr (bus.imem_data),
    .i_pc    (r_pc),
    .o_instr (bus.id_instr),
    .o_pc    (bus.id_pc),
    .o_valid (bus.id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a behavioural model
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOPW = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.dataWidth(32)) bus ();

  logic [31:0] mem [0:63];
  assign bus.imem_data = mem[bus.imem_addr[5:0]];

  fetch_unit #(
    .dataWidth (32),
    .RESET_PC  (RPC),
    .HALT_WORD (HLT),
    .NOP_WORD  (NOPW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: where fetch points, whether it is settling after reset or parked, what decode sees
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_parked;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RPC;
    m_boot   = 1'b1;
    m_parked = 1'b0;
    e_instr  = NOPW;
    e_pc     = 32'h0;
    e_valid  = 1'b0;
  endtask

  // What one clock edge does, given the inputs currently applied
  task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] word;
    word = mem[m_pc[5:0]];
    if (rd) begin
      m_pc     = tgt;
      m_boot   = 1'b0;
      m_parked = 1'b0;
      e_instr  = NOPW;
      e_pc     = 32'h0;
      e_valid  = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_boot) begin
      m_boot  = 1'b0;
      e_instr = NOPW;
      e_valid = 1'b0;
    end else if (m_parked) begin
      e_instr = NOPW;
      e_valid = 1'b0;
    end else begin
      e_instr = word;
      e_pc    = m_pc;
      e_valid = 1'b1;
      if (word == HLT) m_parked = 1'b1;
      else             m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("id_instr", bus.id_instr, e_instr);
    chk("id_valid", {31'b0, bus.id_valid}, {31'b0, e_valid});
    if (e_valid) chk("id_pc", bus.id_pc, e_pc);
    chk("halted", {31'b0, bus.halted}, {31'b0, m_parked});
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    bus.stall           = st;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    model_edge(st, rd, tgt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h11;
    mem[1]  = 32'h22;
    mem[2]  = 32'h33;
    mem[3]  = 32'h44;
    mem[4]  = 32'h55;
    mem[5]  = 32'h66;
    mem[16] = 32'hA0;
    model_reset();

    // Reset state
    #12;
    chk("rst_addr", bus.imem_addr, RPC);
    chk("rst_instr", bus.id_instr, NOPW);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);
    rst_n = 1'b1;

    // BOOT cycle, then sequential fetch from 0
    cycle(1'b0, 1'b0, 32'h0);
    chk("boot_addr_holds", bus.imem_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("first_capture", bus.id_instr, 32'h11);
    cycle(1'b0, 1'b0, 32'h0);
    chk("second_capture_pc", bus.id_pc, 32'h1);

    // Stall three cycles with 0x22 in decode
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("stall_hold_instr", bus.id_instr, 32'h22);
    cycle(1'b0, 1'b0, 32'h0);
    chk("after_stall_instr", bus.id_instr, 32'h33);
    chk("after_stall_pc", bus.id_pc, 32'h2);

    // Advance to PC=5, then redirect to 0x10
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("pc_at_5", bus.imem_addr, 32'h5);
    cycle(1'b0, 1'b1, 32'h10);
    chk("redir_addr", bus.imem_addr, 32'h10);
    chk("redir_bubble_pc", bus.id_pc, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("redir_target_pc", bus.id_pc, 32'h10);

    // Stall together with redirect: redirect wins
    cycle(1'b1, 1'b1, 32'h10);
    chk("stall_redir_bubble", {31'b0, bus.id_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // Halt word at address 3, then release by redirect to 0
    mem[3] = HLT;
    cycle(1'b0, 1'b1, 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("halt_word_delivered", bus.id_instr, HLT);
    chk("halt_word_pc", bus.id_pc, 32'h3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("halt_parked_addr", bus.imem_addr, 32'h3);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0);
    chk("halt_released", {31'b0, bus.halted}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("restart_at_0", bus.id_instr, 32'h11);

    // PC wraps from all-ones to zero
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_id_pc", bus.id_pc, 32'hFFFF_FFFF);

    // Asynchronous reset mid-run at PC=7
    cycle(1'b0, 1'b1, 32'h5);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("pc_at_7", bus.imem_addr, 32'h7);
    rst_n = 1'b0;
    #2;
    chk("midrst_addr", bus.imem_addr, RPC);
    chk("midrst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("midrst_halted", {31'b0, bus.halted}, 32'h0);
    model_reset();
    #3;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("reboot_bubble", {31'b0, bus.id_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("reboot_capture", bus.id_instr, 32'h11);

    // Randomized phase: random program with sprinkled halt words
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 7) == 0) mem[i] = HLT;
      else                           mem[i] = $urandom & 32'h7FFF_FFFF;
    end
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFC0 | $urandom_range(0, 63))
                                        : 32'($urandom_range(0, 63));
      cycle(st, rd, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
